// File: rtl/gift_state_unloader_pkg.sv
// Shared GIFT definitions: state width, unloader FSM encoding,
// and the legal output word width check used by loader/unloader.
package gift_pkg;

    localparam int GIFT_STATE_W = 128;

    typedef logic [0:0] unl_state_t;

    localparam unl_state_t UNL_IDLE = 1'b0;
    localparam unl_state_t UNL_SEND = 1'b1;

    function automatic bit gift_word_w_ok(input int w);
        return (w == 8) || (w == 16) || (w == 32) ||
               (w == 64) || (w == 128);
    endfunction

endpackage

// File: rtl/gift_state_unloader.sv
// Captures the final GIFT state and streams it out as WORD_W words.
// Build option: GIFT_UNLOAD_MSW_FIRST_EN sends most significant word first.
module gift_state_unloader
    import gift_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                    inClk,
    input  logic                    inRstN,
    input  logic                    inCapture,
    input  logic [GIFT_STATE_W-1:0] inState,
    input  logic                    inReady,
    output logic                    outValid,
    output logic [WORD_W-1:0]       outWord,
    output logic                    outLast,
    output logic                    outBusy,
    output logic                    outDrop
);

    localparam int NWORDS = GIFT_STATE_W / WORD_W;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

    if (!gift_word_w_ok(WORD_W)) begin : g_bad_word_w
        $error("gift_state_unloader: illegal WORD_W");
    end

    unl_state_t              r_state;
    logic [GIFT_STATE_W-1:0] r_shadow;
    logic [CW-1:0]           r_cnt;
    logic                    r_drop;

    logic [CW-1:0]           w_idx;
    logic [7:0]              w_base;
    logic [WORD_W-1:0]       w_word;
    logic                    w_send;
    logic                    w_last;

`ifdef GIFT_UNLOAD_MSW_FIRST_EN
    assign w_idx  = LAST_IDX - r_cnt;
`else
    assign w_idx  = r_cnt;
`endif
    assign w_base = 8'(w_idx) * 8'(WORD_W);
    assign w_word = WORD_W'(r_shadow >> w_base);
    assign w_send = (r_state == UNL_SEND);
    assign w_last = w_send && (r_cnt == LAST_IDX);

    assign outValid = w_send;
    assign outBusy  = w_send;
    assign outLast  = w_last;
    assign outWord  = w_send ? w_word : '0;
    assign outDrop  = r_drop;

    // Capture, word sequencing and rejected-capture pulse
    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            r_state  <= UNL_IDLE;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (r_state == UNL_IDLE) begin
                if (inCapture) begin
                    r_shadow <= inState;
                    r_cnt    <= '0;
                    r_state  <= UNL_SEND;
                end
            end else if (inReady && w_last) begin
                r_cnt <= '0;
                if (inCapture) begin
                    r_shadow <= inState;
                end else begin
                    r_state <= UNL_IDLE;
                end
            end else begin
                if (inCapture) begin
                    r_drop <= 1'b1;
                end
                if (inReady) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gift_state_unloader.sv
// Directed bench for gift_state_unloader with 32, 8 and 128-bit words.
// Honours GIFT_UNLOAD_MSW_FIRST_EN when computing expected word order.
module tb_gift_state_unloader;

    localparam logic [127:0] BA =
        128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BB =
        128'hFFEEDDCC_BBAA9988_77665544_33221100;

    logic         clk;
    logic         rst_n;
    logic         cap;
    logic [127:0] st;
    logic         rdy;

    logic         v32, l32, b32, d32;
    logic [31:0]  w32;
    logic         v8, l8, b8, d8;
    logic [7:0]   w8;
    logic         v128, l128, b128, d128;
    logic [127:0] w128;

    int n_chk;
    int n_fail;

    gift_state_unloader #(.WORD_W(32)) u32 (
        .inClk(clk), .inRstN(rst_n), .inCapture(cap),
        .inState(st), .inReady(rdy), .outValid(v32),
        .outWord(w32), .outLast(l32), .outBusy(b32),
        .outDrop(d32)
    );

    gift_state_unloader #(.WORD_W(8)) u8 (
        .inClk(clk), .inRstN(rst_n), .inCapture(cap),
        .inState(st), .inReady(rdy), .outValid(v8),
        .outWord(w8), .outLast(l8), .outBusy(b8),
        .outDrop(d8)
    );

    gift_state_unloader #(.WORD_W(128)) u128 (
        .inClk(clk), .inRstN(rst_n), .inCapture(cap),
        .inState(st), .inReady(rdy), .outValid(v128),
        .outWord(w128), .outLast(l128), .outBusy(b128),
        .outDrop(d128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected 32-bit word k of block b in transmit order
    function automatic logic [31:0] ew32(
        input logic [127:0] b, input int k);
        int j;
`ifdef GIFT_UNLOAD_MSW_FIRST_EN
        j = 3 - k;
`else
        j = k;
`endif
        return b[j*32 +: 32];
    endfunction

    function automatic logic [7:0] ew8(
        input logic [127:0] b, input int k);
        int j;
`ifdef GIFT_UNLOAD_MSW_FIRST_EN
        j = 15 - k;
`else
        j = k;
`endif
        return b[j*8 +: 8];
    endfunction

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic ev,
                         input logic [31:0] ew, input logic el,
                         input logic ed);
        chk({nm, ".valid"}, 128'(v32), 128'(ev));
        chk({nm, ".word"},  128'(w32), 128'(ew));
        chk({nm, ".last"},  128'(l32), 128'(el));
        chk({nm, ".busy"},  128'(b32), 128'(ev));
        chk({nm, ".drop"},  128'(d32), 128'(ed));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rdy;
        logic       cap;
        int         blk;
        logic       ev;
        int         ebk;
        int         ek;
        logic       el;
        logic       ed;
    } vec_t;

    vec_t vt[15];

    function automatic logic [127:0] blkv(input int i);
        return (i == 1) ? BB : BA;
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        cap    = 1'b0;
        st     = '0;
        rdy    = 1'b0;

        //       rdy  cap blk  ev  ebk ek  el  ed
        vt[0]  = '{1'b1, 1'b1, 0, 1'b1, 0, 0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 0, 1'b1, 0, 1, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 0, 1'b1, 0, 1, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 0, 1'b1, 0, 1, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 0, 1'b1, 0, 1, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 0, 1'b1, 0, 2, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 1, 1'b1, 0, 2, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 0, 1'b1, 0, 3, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1, 1'b1, 1, 0, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 0, 1'b1, 1, 1, 1'b0, 1'b1};
        vt[10] = '{1'b1, 1'b0, 0, 1'b1, 1, 2, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 0, 1'b1, 1, 3, 1'b1, 1'b0};
        vt[12] = '{1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};

        // reset state
        tick();
        tick();
        chk32("reset", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("reset.v8",   128'(v8),   128'(0));
        chk("reset.v128", 128'(v128), 128'(0));
        rst_n = 1'b1;
        tick();
        chk32("idle", 1'b0, 32'h0, 1'b0, 1'b0);

        // table: stream, backpressure, drop, back-to-back
        for (int i = 0; i < 15; i++) begin
            rdy = vt[i].rdy;
            cap = vt[i].cap;
            st  = blkv(vt[i].blk);
            tick();
            chk32($sformatf("vec%0d", i), vt[i].ev,
                  vt[i].ev ? ew32(blkv(vt[i].ebk), vt[i].ek)
                           : 32'h0,
                  vt[i].el, vt[i].ed);
        end
        cap = 1'b0;

        // reset during word 2, with capture asserted
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rdy = 1'b1;
        cap = 1'b1;
        st  = BA;
        tick();
        cap = 1'b0;
        chk32("rs.w0", 1'b1, ew32(BA, 0), 1'b0, 1'b0);
        tick();
        chk32("rs.w1", 1'b1, ew32(BA, 1), 1'b0, 1'b0);
        tick();
        chk32("rs.w2", 1'b1, ew32(BA, 2), 1'b0, 1'b0);
        rst_n = 1'b0;
        cap   = 1'b1;
        st    = BB;
        tick();
        chk32("rs.clr", 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cap   = 1'b0;
        tick();
        chk32("rs.idle", 1'b0, 32'h0, 1'b0, 1'b0);
        cap = 1'b1;
        st  = BB;
        tick();
        cap = 1'b0;
        chk32("rs.new0", 1'b1, ew32(BB, 0), 1'b0, 1'b0);

        // wide and narrow builds from a clean start
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rdy = 1'b1;
        cap = 1'b1;
        st  = BA;
        tick();
        cap = 1'b0;
        chk("w128.valid", 128'(v128), 128'(1));
        chk("w128.word",  w128, BA);
        chk("w128.last",  128'(l128), 128'(1));
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("w8.valid%0d", k), 128'(v8), 128'(1));
            chk($sformatf("w8.word%0d", k),
                128'(w8), 128'(ew8(BA, k)));
            chk($sformatf("w8.last%0d", k),
                128'(l8), 128'(k == 15));
            if (k == 0) begin
                chk("w128.after", 128'(v128), 128'(1));
            end
            tick();
            if (k == 0) begin
                chk("w128.idle", 128'(v128), 128'(0));
            end
        end
        chk("w8.idle", 128'(v8), 128'(0));
        chk("w8.busy", 128'(b8), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
